vector_floating_point_square_root_iterative_unit: RTL and testbench

Multi-cycle, handshaked vector FP32 square root unit. It splits a VLEN-bit operand into VLEN/32 independent lanes and runs a digit-recurrence square root in every lane in lockstep. It adds masking, dynamic rounding mode, exception flags and subnormal support. It sits in the vector floating-point execution cluster, fed by the issue stage and drained by writeback through valid/ready handshakes.

---
 rtl/dragonfang_floating_point_pkg.sv | 59 +++++
 rtl/vector_floating_point_square_root_lane.sv | 167 ++++++++++++++++
 rtl/vector_floating_point_square_root_iterative_unit.sv | 132 +++++++++++++
 tb/tb_vector_floating_point_square_root_iterative_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dragonfang_floating_point_pkg.sv
// Shared FP32 definitions for the vector floating-point cluster: field widths,
// rounding modes, exception flag positions and the square-root FSM encoding.
package dragonfang_floating_point_pkg;

    localparam int FP32_WIDTH      = 32;
    localparam int FP32_EXP_WIDTH  = 8;
    localparam int FP32_FRAC_WIDTH = 23;
    localparam int FP32_SIG_WIDTH  = 24;
    localparam int SQRT_ROOT_BITS  = 26;

    localparam logic [31:0] FP32_CANONICAL_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP32_POS_INF       = 32'h7F80_0000;

    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef enum logic [2:0] {
        FRM_RNE = 3'b000,
        FRM_RTZ = 3'b001,
        FRM_RDN = 3'b010,
        FRM_RUP = 3'b011,
        FRM_RMM = 3'b100
    } frm_e;

    typedef enum logic [2:0] {
        SQRT_IDLE,
        SQRT_UNPACK,
        SQRT_ITERATE,
        SQRT_ROUND,
        SQRT_DONE
    } sqrt_state_e;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_FINITE,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } fp_class_e;

    // Leading-zero count of a 24-bit significand; 24 when the value is zero.
    function automatic logic [4:0] lzc24(input logic [23:0] value);
        logic [4:0] count;
        logic       found;
        count = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && value[i]) begin
                count = 5'(23 - i);
                found = 1'b1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/vector_floating_point_square_root_lane.sv
// One FP32 lane: unpack/normalise, restoring square-root recurrence and
// round/pack, each phase enabled by a strobe from the shared FSM.
module vector_floating_point_square_root_lane
    import dragonfang_floating_point_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] operand,
    input  logic [31:0] old_value,
    input  logic        active,
    input  frm_e        frm,
    input  logic        load,
    input  logic        step,
    input  logic        finish,
    output logic [31:0] result,
    output logic [4:0]  flags
);

    logic        sign_reg;
    fp_class_e   class_reg;
    logic [7:0]  exp_base_reg;
    logic [25:0] rad_reg;
    logic [29:0] rem_reg;
    logic [25:0] root_reg;
    logic [31:0] result_reg;
    logic [4:0]  flags_reg;

    logic [7:0]  exp_field;
    logic [22:0] frac_field;
    fp_class_e   class_next;
    logic [4:0]  lz;
    logic [23:0] sig_norm;
    logic [8:0]  exp_sum;
    logic [25:0] rad_next;

    // exp_sum = unbiased exponent + 252, so [8:1] is the packed result
    // exponent minus one (the root's hidden bit adds it back) and [0] is odd.
    always_comb begin
        exp_field  = operand[30:23];
        frac_field = operand[22:0];
        class_next = CLS_FINITE;
        if (exp_field == 8'hFF) begin
            if (frac_field == 23'd0)
                class_next = CLS_INF;
            else if (frac_field[22])
                class_next = CLS_QNAN;
            else
                class_next = CLS_SNAN;
        end else if (exp_field == 8'h00 && frac_field == 23'd0) begin
            class_next = CLS_ZERO;
        end
        lz = lzc24({1'b0, frac_field});
        if (exp_field != 8'h00) begin
            sig_norm = {1'b1, frac_field};
            exp_sum  = {1'b0, exp_field} + 9'd125;
        end else begin
            sig_norm = {1'b0, frac_field} << lz;
            exp_sum  = 9'd126 - {4'b0000, lz};
        end
        if (exp_sum[0])
            rad_next = {sig_norm, 2'b00};
        else
            rad_next = {1'b0, sig_norm, 1'b0};
    end

    logic [29:0] rem_step;
    logic [25:0] root_step;
    logic [25:0] rad_step;
    logic [29:0] trial;

    // Radicand bits are consumed two at a time; once exhausted, zeros follow.
    always_comb begin
        rem_step  = rem_reg;
        root_step = root_reg;
        rad_step  = rad_reg;
        trial     = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            rem_step = {rem_step[27:0], rad_step[25:24]};
            rad_step = {rad_step[23:0], 2'b00};
            trial    = {2'b00, root_step, 2'b01};
            if (rem_step >= trial) begin
                rem_step  = rem_step - trial;
                root_step = {root_step[24:0], 1'b1};
            end else begin
                root_step = {root_step[24:0], 1'b0};
            end
        end
    end

    logic        guard_bit;
    logic        round_bit;
    logic        sticky_bit;
    logic        inexact;
    logic        increment;
    logic [31:0] packed_value;
    logic [31:0] result_next;
    logic [4:0]  flags_next;

    always_comb begin
        guard_bit  = root_reg[1];
        round_bit  = root_reg[0];
        sticky_bit = |rem_reg;
        inexact    = guard_bit | round_bit | sticky_bit;
        case (frm)
            FRM_RTZ, FRM_RDN: increment = 1'b0;
            FRM_RUP:          increment = inexact;
            FRM_RMM:          increment = guard_bit;
            default:          increment = guard_bit & (round_bit | sticky_bit | root_reg[2]);
        endcase
        // A carry out of the mantissa rolls into the exponent field naturally.
        packed_value = {1'b0, exp_base_reg, 23'd0} + {8'd0, root_reg[25:2]}
                     + {31'd0, increment};
        result_next = packed_value;
        flags_next  = '0;
        if (!active) begin
            result_next = old_value;
        end else if (class_reg == CLS_ZERO) begin
            result_next = {sign_reg, 31'd0};
        end else if (class_reg == CLS_QNAN) begin
            result_next = FP32_CANONICAL_NAN;
        end else if (class_reg == CLS_SNAN || sign_reg) begin
            result_next = FP32_CANONICAL_NAN;
            flags_next[FFLAG_NV] = 1'b1;
        end else if (class_reg == CLS_INF) begin
            result_next = FP32_POS_INF;
        end else begin
            flags_next[FFLAG_NX] = inexact;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sign_reg     <= 1'b0;
            class_reg    <= CLS_ZERO;
            exp_base_reg <= '0;
            rad_reg      <= '0;
            rem_reg      <= '0;
            root_reg     <= '0;
            result_reg   <= '0;
            flags_reg    <= '0;
        end else begin
            if (load) begin
                sign_reg     <= operand[31];
                class_reg    <= class_next;
                exp_base_reg <= exp_sum[8:1];
                rad_reg      <= rad_next;
                rem_reg      <= '0;
                root_reg     <= '0;
            end
            if (step) begin
                rad_reg  <= rad_step;
                rem_reg  <= rem_step;
                root_reg <= root_step;
            end
            if (finish) begin
                result_reg <= result_next;
                flags_reg  <= flags_next;
            end
        end
    end

    assign result = result_reg;
    assign flags  = flags_reg;

endmodule

// File: rtl/vector_floating_point_square_root_iterative_unit.sv
// Vector FP32 square root: shared handshake FSM and iteration counter driving
// LANES lockstep digit-recurrence lanes; flags are ORed across lanes.
module vector_floating_point_square_root_iterative_unit
    import dragonfang_floating_point_pkg::*;
#(
    parameter int VLEN           = 128,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [VLEN-1:0]      vs2,
    input  logic [VLEN-1:0]      vd_old,
    input  logic [VLEN/32-1:0]   mask,
    input  logic [2:0]           frm,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [VLEN-1:0]      vd,
    output logic [4:0]           fflags
);

    localparam int LANES       = VLEN / 32;
    localparam int ITER_CYCLES = SQRT_ROOT_BITS / BITS_PER_CYCLE;
    localparam logic [4:0] ITER_LAST = 5'(ITER_CYCLES - 1);

    sqrt_state_e      state_reg;
    logic [4:0]       counter_reg;
    logic             out_valid_reg;
    logic [VLEN-1:0]  vs2_reg;
    logic [VLEN-1:0]  vd_old_reg;
    logic [LANES-1:0] mask_reg;
    frm_e             frm_reg;

    logic accept;
    logic load_strobe;
    logic step_strobe;
    logic finish_strobe;

    assign in_ready      = (state_reg == SQRT_IDLE) | ((state_reg == SQRT_DONE) & out_ready);
    assign accept        = in_valid & in_ready & ~flush;
    assign load_strobe   = (state_reg == SQRT_UNPACK) & ~flush;
    assign step_strobe   = (state_reg == SQRT_ITERATE) & ~flush;
    assign finish_strobe = (state_reg == SQRT_ROUND) & ~flush;
    assign out_valid     = out_valid_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= SQRT_IDLE;
            counter_reg   <= '0;
            out_valid_reg <= 1'b0;
            vs2_reg       <= '0;
            vd_old_reg    <= '0;
            mask_reg      <= '0;
            frm_reg       <= FRM_RNE;
        end else if (flush) begin
            state_reg     <= SQRT_IDLE;
            out_valid_reg <= 1'b0;
        end else begin
            if (accept) begin
                vs2_reg    <= vs2;
                vd_old_reg <= vd_old;
                mask_reg   <= mask;
                frm_reg    <= frm_e'(frm);
            end
            case (state_reg)
                SQRT_IDLE: begin
                    if (in_valid)
                        state_reg <= SQRT_UNPACK;
                end
                SQRT_UNPACK: begin
                    counter_reg <= ITER_LAST;
                    state_reg   <= SQRT_ITERATE;
                end
                SQRT_ITERATE: begin
                    if (counter_reg == 5'd0)
                        state_reg <= SQRT_ROUND;
                    else
                        counter_reg <= counter_reg - 5'd1;
                end
                SQRT_ROUND: begin
                    state_reg     <= SQRT_DONE;
                    out_valid_reg <= 1'b1;
                end
                SQRT_DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= in_valid ? SQRT_UNPACK : SQRT_IDLE;
                    end
                end
                default: state_reg <= SQRT_IDLE;
            endcase
        end
    end

    logic [31:0] lane_result [LANES];
    logic [4:0]  lane_flags  [LANES];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            vector_floating_point_square_root_lane #(
                .BITS_PER_CYCLE(BITS_PER_CYCLE)
            ) u_lane (
                .clock     (clock),
                .reset_n   (reset_n),
                .operand   (vs2_reg[32*gi +: 32]),
                .old_value (vd_old_reg[32*gi +: 32]),
                .active    (mask_reg[gi]),
                .frm       (frm_reg),
                .load      (load_strobe),
                .step      (step_strobe),
                .finish    (finish_strobe),
                .result    (lane_result[gi]),
                .flags     (lane_flags[gi])
            );
            assign vd[32*gi +: 32] = lane_result[gi];
        end
    endgenerate

    logic [4:0] flags_or;

    always_comb begin
        flags_or = '0;
        for (int i = 0; i < LANES; i++)
            flags_or = flags_or | lane_flags[i];
    end

    assign fflags = flags_or;

endmodule

// File: tb/tb_vector_floating_point_square_root_iterative_unit.sv
// Directed bench for the vector FP32 square-root unit: hand-computed results,
// latency, backpressure, flush and asynchronous reset behaviour.
module tb_vector_floating_point_square_root_iterative_unit;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] vs2 = '0;
    logic [127:0] vd_old = '0;
    logic [3:0]   mask = '0;
    logic [2:0]   frm = 3'b000;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] vd;
    logic [4:0]   fflags;

    int checks = 0;
    int errors = 0;
    int op_count = 0;
    int latency;
    logic saw_valid;

    localparam logic [127:0] BASIC_VS2   = {32'h00000000, 32'h40000000, 32'h3F800000, 32'h40800000};
    localparam logic [127:0] BASIC_VD    = {32'h00000000, 32'h3FB504F3, 32'h3F800000, 32'h40000000};
    localparam logic [127:0] ROUND_VS2   = {32'h40000000, 32'h00000001, 32'h7F7FFFFF, 32'h40000000};
    localparam logic [127:0] ROUND_DOWN  = {32'h3FB504F3, 32'h1A3504F3, 32'h5F7FFFFF, 32'h3FB504F3};
    localparam logic [127:0] ROUND_UP    = {32'h3FB504F4, 32'h1A3504F4, 32'h5F800000, 32'h3FB504F4};
    localparam logic [127:0] SPECIAL_VS2 = {32'h00200000, 32'h7F800001, 32'h80000000, 32'hBF800000};
    localparam logic [127:0] SPECIAL_VD  = {32'h1F800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000};
    localparam logic [127:0] INF_VS2     = {32'h3F800000, 32'h3E800000, 32'hFFC00000, 32'h7F800000};
    localparam logic [127:0] INF_VD      = {32'h3F800000, 32'h3F000000, 32'h7FC00000, 32'h7F800000};
    localparam logic [127:0] MASK_VS2    = {32'h40000000, 32'h3F800000, 32'hBF800000, 32'h40800000};
    localparam logic [127:0] MASK_OLD    = {4{32'hDEADBEEF}};
    localparam logic [127:0] MASK_VD     = {32'hDEADBEEF, 32'h3F800000, 32'hDEADBEEF, 32'h40000000};

    always #5 clock = ~clock;

    vector_floating_point_square_root_iterative_unit #(
        .VLEN           (128),
        .BITS_PER_CYCLE (1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .vs2       (vs2),
        .vd_old    (vd_old),
        .mask      (mask),
        .frm       (frm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vd        (vd),
        .fflags    (fflags)
    );

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents a request, lets it be accepted on the next edge, then scrambles
    // the inputs so any late re-sampling corrupts the result.
    task automatic start_op(input logic [127:0] vs2_in, input logic [127:0] old_in,
                            input logic [3:0] mask_in, input logic [2:0] frm_in);
        vs2      = vs2_in;
        vd_old   = old_in;
        mask     = mask_in;
        frm      = frm_in;
        in_valid = 1'b1;
        check("in_ready_before_accept", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        vs2      = ~vs2_in;
        vd_old   = ~old_in;
        mask     = ~mask_in;
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 100) begin
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic [127:0] vs2_in, input logic [127:0] old_in,
                          input logic [3:0] mask_in, input logic [2:0] frm_in,
                          input logic [127:0] exp_vd, input logic [4:0] exp_flags);
        int cycles;
        start_op(vs2_in, old_in, mask_in, frm_in);
        wait_result(cycles);
        check({tag, "_latency"}, 128'(cycles), 128'd28);
        check({tag, "_vd"}, vd, exp_vd);
        check({tag, "_fflags"}, {123'd0, fflags}, {123'd0, exp_flags});
        op_count++;
        $display("op %0d %s: vd=%h fflags=%b latency=%0d", op_count, tag, vd, fflags, cycles);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        check("reset_in_ready", {127'd0, in_ready}, 128'd1);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_vd", vd, 128'd0);
        check("reset_fflags", {123'd0, fflags}, 128'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        run_op("basic_rne", BASIC_VS2, 128'd0, 4'b1111, 3'b000, BASIC_VD, 5'b00001);
        run_op("round_rne", ROUND_VS2, 128'd0, 4'b1111, 3'b000, ROUND_DOWN, 5'b00001);
        run_op("round_rtz", ROUND_VS2, 128'd0, 4'b1111, 3'b001, ROUND_DOWN, 5'b00001);
        run_op("round_rdn", ROUND_VS2, 128'd0, 4'b1111, 3'b010, ROUND_DOWN, 5'b00001);
        run_op("round_rup", ROUND_VS2, 128'd0, 4'b1111, 3'b011, ROUND_UP, 5'b00001);
        run_op("round_rmm", ROUND_VS2, 128'd0, 4'b1111, 3'b100, ROUND_DOWN, 5'b00001);
        run_op("specials", SPECIAL_VS2, 128'd0, 4'b1111, 3'b000, SPECIAL_VD, 5'b10000);
        run_op("inf_qnan", INF_VS2, 128'd0, 4'b1111, 3'b000, INF_VD, 5'b00000);
        run_op("masking", MASK_VS2, MASK_OLD, 4'b0101, 3'b000, MASK_VD, 5'b00000);

        // Backpressure: result must be held while the consumer stalls.
        tick();
        out_ready = 1'b0;
        start_op(BASIC_VS2, 128'd0, 4'b1111, 3'b000);
        wait_result(latency);
        check("bp_latency", 128'(latency), 128'd28);
        vs2      = SPECIAL_VS2;
        vd_old   = 128'd0;
        mask     = 4'b1111;
        frm      = 3'b000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_vd", vd, BASIC_VD);
            check("bp_hold_ctrl", {121'd0, out_valid, in_ready, fflags}, {121'd0, 1'b1, 1'b0, 5'b00001});
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        vs2      = ~SPECIAL_VS2;
        check("bp_after_accept_ctrl", {126'd0, out_valid, in_ready}, 128'd0);
        wait_result(latency);
        check("bp_second_latency", 128'(latency), 128'd28);
        check("bp_second_vd", vd, SPECIAL_VD);
        check("bp_second_fflags", {123'd0, fflags}, {123'd0, 5'b10000});
        op_count++;
        $display("op %0d backpressure: vd=%h fflags=%b latency=%0d", op_count, vd, fflags, latency);

        // Flush in the 5th iteration cycle.
        tick();
        start_op(BASIC_VS2, 128'd0, 4'b1111, 3'b000);
        repeat (5) tick();
        check("flush_busy_in_ready", {127'd0, in_ready}, 128'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_in_ready", {127'd0, in_ready}, 128'd1);
        check("flush_out_valid", {127'd0, out_valid}, 128'd0);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            saw_valid = saw_valid | out_valid;
        end
        check("flush_never_valid", {127'd0, saw_valid}, 128'd0);

        // Flush wins over a simultaneous request.
        vs2      = BASIC_VS2;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_priority_in_ready", {127'd0, in_ready}, 128'd1);
        op_count++;
        $display("op %0d flush: in_ready=%b out_valid=%b", op_count, in_ready, out_valid);

        // Asynchronous reset in the middle of iterating.
        tick();
        start_op(SPECIAL_VS2, 128'd0, 4'b1111, 3'b000);
        repeat (10) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_vd", vd, 128'd0);
        check("async_reset_ctrl", {121'd0, out_valid, in_ready, fflags}, {121'd0, 1'b0, 1'b1, 5'b00000});
        op_count++;
        $display("op %0d reset: vd=%h fflags=%b out_valid=%b", op_count, vd, fflags, out_valid);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        run_op("after_reset", BASIC_VS2, 128'd0, 4'b1111, 3'b000, BASIC_VD, 5'b00001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
